dotprod_loader: RTL
===================

// Module: dotprod_loader
// PURPOSE
//  Upstream feeder for the dotprod engine. Accepts a valid/ready stream of (a,b) element pairs.
//  Collects them into 8-lane A/B holding registers, presents them on a0..a7/b0..b7, pulses start.
//  Then holds the lanes stable until dotprod signals done; one vector in flight at a time.
// PARAMETERS
//  DATA_W          32   element width; matches dotprod a*/b* port width
//  N_ELEM          8    lanes per vector; fixed at 8 by dotprod port list
//  TIMEOUT_CYCLES  0    max WAIT cycles before abort; 0 = timeout disabled
//  CNT_W           16   width of vec_count
// PORTS
//  clk        in   1       single clock, rising edge
//  rst        in   1       synchronous reset, active-high
//  in_valid   in   1       element pair valid
//  in_ready   out  1       loader can accept an element pair
//  in_a       in   DATA_W  A element
//  in_b       in   DATA_W  B element
//  in_last    in   1       last element of short vector (only with DOTPROD_LOADER_ZEROPAD_EN)
//  a0..a7     out  DATA_W  A lanes to dotprod
//  b0..b7     out  DATA_W  B lanes to dotprod
//  start      out  1       one-cycle launch pulse to dotprod
//  done       in   1       dotprod completion (pulse or level)
//  busy       out  1       vector launched, awaiting done
//  vec_count  out  CNT_W   completed vectors, wraps modulo 2^CNT_W
//  timeout    out  1       sticky abort flag, cleared only by rst
// BEHAVIOUR
//  Reset: state=FILL, idx=0, all lanes=0, start=0, busy=0, vec_count=0, timeout=0, done_q=0.
//  in_ready=0 while rst is high.
//  FSM FILL -> LAUNCH -> WAIT -> FILL.
//  FILL:
//   - in_ready=1.
//   - On in_valid&&in_ready: lane[idx] <= {in_a,in_b}; idx++.
//   - Accepting idx==N_ELEM-1 -> LAUNCH, idx<=0.
//  LAUNCH:
//   - in_ready=0, start=1 for exactly this cycle -> WAIT.
//   - Lanes are stable from this cycle through WAIT exit.
//  WAIT:
//   - in_ready=0, busy=1.
//   - Exit on rising edge of done (done && !done_q) -> FILL.
//   - On exit, vec_count++.
//   - A done that is already high on WAIT entry is ignored until it falls and rises again.
//  Timeout (TIMEOUT_CYCLES>0):
//   - WAIT counter reaches TIMEOUT_CYCLES with no done edge -> timeout<=1, FILL.
//   - vec_count is not incremented.
//  Latency: last element accept at cycle T -> start at T+1.
//  Lanes are written only in FILL. Inputs in LAUNCH/WAIT are not accepted; upstream holds in_valid.
//  rst mid-operation (any state) wins over every other event next edge; in-flight vector discarded.
//  done outside WAIT: only updates done_q; no other effect.
//  Lanes hold the previous vector until overwritten lane by lane.
//  in_a/in_b/in_last are don't-care when in_valid=0.
// CONFIGURATION
//  DOTPROD_LOADER_ZEROPAD_EN defined:
//   - in_last port exists.
//   - Accepting in_last=1 at idx=k<7: lanes k+1..7 of A and B are zeroed in the same cycle; -> LAUNCH.
//   - in_last at idx=7 behaves as a normal full vector.
//  Not defined:
//   - in_last port is absent.
//   - Every vector is exactly 8 pairs; no zeroing logic.
// STRUCTURE
//  dotprod_pkg:
//   - localparams DATA_W=32, N_ELEM=8, RES_W=64.
//   - typedef enum logic[1:0] {LD_FILL,LD_LAUNCH,LD_WAIT} loader_state_t.
//   - typedef logic[DATA_W-1:0] elem_t.
//  Sub-module dotprod_loader_timer: WAIT-cycle counter + timeout compare.
//   - Omitted by generate when TIMEOUT_CYCLES==0.
//  Lane storage: elem_t arrays, indexed by idx[2:0]; done edge detect inline.
// TESTING
//  1 Full vector:
//    - Stream A=1..8, B=8..1 with in_valid held high.
//    - start pulses once, cycle after 8th accept; dotprod result=120; vec_count=1.
//  2 Backpressure:
//    - Offer 9th pair during WAIT; in_ready=0; pair not consumed.
//    - Pair is accepted as lane 0 of the next vector after done edge.
//  3 Level done:
//    - Hold done=1 across next launch; no premature WAIT exit.
//    - Exit only after done 1->0->1.
//  4 Reset mid-WAIT:
//    - rst at WAIT cycle 3: next cycle state FILL, a0..b7=0, start=0, vec_count=0.
//    - in_ready=1 the cycle after rst falls.
//  5 Timeout (TIMEOUT_CYCLES=20):
//    - Never assert done: timeout=1 at WAIT cycle 20; return to FILL; vec_count unchanged.
//  6 ZEROPAD_EN:
//    - Stream A=3,4,5 / B=2,2,2, in_last on 3rd pair.
//    - a3..a7 and b3..b7 = 0; start fires; result=24.

Source files
------------

// File: rtl/dotprod_pkg.sv
// -----------------------------------------------------------------------------
// dotprod_pkg
// Shared types and constants for the dotprod engine and its loader.
//   DATA_W          element width of the dotprod a*/b* lanes
//   N_ELEM          lanes per vector (fixed by the dotprod port list)
//   RES_W           width of a full dot-product result
//   loader_state_t  loader FSM states
//   elem_t          one lane element
// -----------------------------------------------------------------------------
package dotprod_pkg;

   localparam int DATA_W = 32;
   localparam int N_ELEM = 8;
   localparam int RES_W  = 64;

   typedef enum logic [1:0] {
      LD_FILL   = 2'd0,
      LD_LAUNCH = 2'd1,
      LD_WAIT   = 2'd2
   } loader_state_t;

   typedef logic [DATA_W-1:0] elem_t;

endpackage

// File: rtl/dotprod_loader_timer.sv
// -----------------------------------------------------------------------------
// dotprod_loader_timer
// Counts consecutive cycles the loader spends waiting for the engine and flags
// expiry on the last allowed WAIT cycle, so the loader can abort the vector.
// Ports:
//   clk      in   rising-edge clock
//   rst      in   synchronous active-high reset
//   in_wait  in   loader is in its WAIT state this cycle
//   expire   out  this is WAIT cycle number TIMEOUT_CYCLES (combinational)
// -----------------------------------------------------------------------------
module dotprod_loader_timer #(
   parameter int TIMEOUT_CYCLES = 20
) (
   input  logic clk,
   input  logic rst,
   input  logic in_wait,
   output logic expire
);

   localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;

   // The count holds (n-1) during the n-th WAIT cycle and is cleared whenever
   // the loader is elsewhere, so every vector gets a fresh budget.
   always_comb begin
      cnt_d  = '0;
      if (in_wait) begin
         cnt_d = cnt_q + 1'b1;
      end
      expire = in_wait && (cnt_q == CW'(TIMEOUT_CYCLES - 1));
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/dotprod_loader.sv
// -----------------------------------------------------------------------------
// dotprod_loader
// Upstream feeder for the dotprod engine. Collects a valid/ready stream of
// (a,b) element pairs into 8 A/B lanes, pulses start for one cycle, then holds
// the lanes stable until the engine's done rises. One vector in flight.
// Optional feature macro: DOTPROD_LOADER_ZEROPAD_EN adds in_last, which ends a
// short vector early and zeroes the unfilled upper lanes.
// Ports:
//   clk, rst            clock and synchronous active-high reset
//   in_valid/in_ready   element-pair handshake
//   in_a, in_b          element pair
//   in_last             last pair of a short vector (ZEROPAD build only)
//   a0..a7, b0..b7      lanes presented to dotprod
//   start               one-cycle launch pulse
//   done                dotprod completion, pulse or level; rising edge used
//   busy                vector launched, awaiting done
//   vec_count           completed vectors, wraps
//   timeout             sticky abort flag, cleared by rst
// -----------------------------------------------------------------------------
module dotprod_loader #(
   parameter int DATA_W         = 32,
   parameter int N_ELEM         = 8,
   parameter int TIMEOUT_CYCLES = 0,
   parameter int CNT_W          = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_a,
   input  logic [DATA_W-1:0] in_b,
`ifdef DOTPROD_LOADER_ZEROPAD_EN
   input  logic              in_last,
`endif
   output logic [DATA_W-1:0] a0,
   output logic [DATA_W-1:0] a1,
   output logic [DATA_W-1:0] a2,
   output logic [DATA_W-1:0] a3,
   output logic [DATA_W-1:0] a4,
   output logic [DATA_W-1:0] a5,
   output logic [DATA_W-1:0] a6,
   output logic [DATA_W-1:0] a7,
   output logic [DATA_W-1:0] b0,
   output logic [DATA_W-1:0] b1,
   output logic [DATA_W-1:0] b2,
   output logic [DATA_W-1:0] b3,
   output logic [DATA_W-1:0] b4,
   output logic [DATA_W-1:0] b5,
   output logic [DATA_W-1:0] b6,
   output logic [DATA_W-1:0] b7,
   output logic              start,
   input  logic              done,
   output logic              busy,
   output logic [CNT_W-1:0]  vec_count,
   output logic              timeout
);

   import dotprod_pkg::*;

   localparam int IDX_W = 3;

   loader_state_t     state_q, state_d;
   logic [IDX_W-1:0]  idx_q, idx_d;
   logic [DATA_W-1:0] lane_a_q [N_ELEM];
   logic [DATA_W-1:0] lane_a_d [N_ELEM];
   logic [DATA_W-1:0] lane_b_q [N_ELEM];
   logic [DATA_W-1:0] lane_b_d [N_ELEM];
   logic [CNT_W-1:0]  vec_count_q, vec_count_d;
   logic              timeout_q, timeout_d;
   logic              done_q;

   logic accept;
   logic done_rise;
   logic timer_expire;

   // in_ready is forced low during reset so nothing is consumed on the
   // edge that reset wins anyway.
   assign in_ready  = (state_q == LD_FILL) && !rst;
   assign accept    = in_valid && in_ready;
   assign done_rise = done && !done_q;
   assign start     = (state_q == LD_LAUNCH);
   assign busy      = (state_q == LD_WAIT);
   assign vec_count = vec_count_q;
   assign timeout   = timeout_q;

   assign a0 = lane_a_q[0];
   assign a1 = lane_a_q[1];
   assign a2 = lane_a_q[2];
   assign a3 = lane_a_q[3];
   assign a4 = lane_a_q[4];
   assign a5 = lane_a_q[5];
   assign a6 = lane_a_q[6];
   assign a7 = lane_a_q[7];
   assign b0 = lane_b_q[0];
   assign b1 = lane_b_q[1];
   assign b2 = lane_b_q[2];
   assign b3 = lane_b_q[3];
   assign b4 = lane_b_q[4];
   assign b5 = lane_b_q[5];
   assign b6 = lane_b_q[6];
   assign b7 = lane_b_q[7];

   // With no timeout configured the timer disappears entirely.
   generate
      if (TIMEOUT_CYCLES > 0) begin : g_timer
         dotprod_loader_timer #(
            .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
         ) u_timer (
            .clk     (clk),
            .rst     (rst),
            .in_wait (state_q == LD_WAIT),
            .expire  (timer_expire)
         );
      end else begin : g_no_timer
         assign timer_expire = 1'b0;
      end
   endgenerate

   // Next-state logic. Lanes only change in FILL, which keeps them stable
   // from the launch pulse until the engine reports done. A done edge in the
   // same cycle as timer expiry counts as a normal completion.
   always_comb begin
      state_d     = state_q;
      idx_d       = idx_q;
      lane_a_d    = lane_a_q;
      lane_b_d    = lane_b_q;
      vec_count_d = vec_count_q;
      timeout_d   = timeout_q;
      case (state_q)
         LD_FILL: begin
            if (accept) begin
               lane_a_d[idx_q] = in_a;
               lane_b_d[idx_q] = in_b;
               if (idx_q == IDX_W'(N_ELEM - 1)) begin
                  state_d = LD_LAUNCH;
                  idx_d   = '0;
               end
`ifdef DOTPROD_LOADER_ZEROPAD_EN
               else if (in_last) begin
                  for (int i = 0; i < N_ELEM; i++) begin
                     if (i > int'(idx_q)) begin
                        lane_a_d[i] = '0;
                        lane_b_d[i] = '0;
                     end
                  end
                  state_d = LD_LAUNCH;
                  idx_d   = '0;
               end
`endif
               else begin
                  idx_d = idx_q + 1'b1;
               end
            end
         end
         LD_LAUNCH: begin
            state_d = LD_WAIT;
         end
         LD_WAIT: begin
            if (done_rise) begin
               state_d     = LD_FILL;
               vec_count_d = vec_count_q + 1'b1;
            end else if (timer_expire) begin
               state_d   = LD_FILL;
               timeout_d = 1'b1;
            end
         end
         default: begin
            state_d = LD_FILL;
         end
      endcase
   end

   // State register. done_q tracks done in every state so a level already
   // high when WAIT is entered never looks like a fresh edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= LD_FILL;
         idx_q       <= '0;
         vec_count_q <= '0;
         timeout_q   <= 1'b0;
         done_q      <= 1'b0;
         for (int i = 0; i < N_ELEM; i++) begin
            lane_a_q[i] <= '0;
            lane_b_q[i] <= '0;
         end
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         vec_count_q <= vec_count_d;
         timeout_q   <= timeout_d;
         done_q      <= done;
         for (int i = 0; i < N_ELEM; i++) begin
            lane_a_q[i] <= lane_a_d[i];
            lane_b_q[i] <= lane_b_d[i];
         end
      end
   end

endmodule
